// File: rtl/sseg_scan_driver_if.sv
// Display-side bundle: digit/dp/blank inputs in, anode/segment drive out.
// master feeds digits and watches the display; slave is the scan driver.
interface sseg_scan_driver_if;
  logic [3:0] digits_in [3:0];
  logic [3:0] dp_in;
  logic       blank_en;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  modport master (
    output digits_in, dp_in, blank_en,
    input  an, sseg, frame_tick
  );

  modport slave (
    input  digits_in, dp_in, blank_en,
    output an, sseg, frame_tick
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// 4-digit multiplexed seven-segment scanner with dead time between digits.
// Ports: clk, reset (async active-low), bus (slave): digits/dp/blank in; an/sseg/frame_tick out.
module sseg_scan_driver #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int DEAD_CYCLES  = 1000,
  parameter int CNT_WIDTH    = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  sseg_scan_driver_if.slave    bus
);

  localparam logic [CNT_WIDTH-1:0] DEAD_LAST = CNT_WIDTH'(DEAD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ON_LAST   = CNT_WIDTH'(DIGIT_CYCLES - 1);

  typedef enum logic {DEAD, ON} state_t;

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           an_q, an_d;
  logic [7:0]           sseg_q, sseg_d;
  logic                 tick_q, tick_d;
  logic                 pend_q;
  logic                 load;
  logic [3:0]           sh_dig [4];
  logic [3:0]           sh_dp;
  logic [3:0]           cur_dig;
  logic                 cur_dp;

  function automatic logic [6:0] seg7(input logic [3:0] v, input logic blank);
    logic [6:0] s;
    s = 7'h7F;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    if (blank && v > 4'd9) s = 7'h7F;
    return s;
  endfunction

  // While the first snapshot is still pending the shadow is stale, so
  // look through to the inputs that are about to be captured.
  always_comb begin
    cur_dig = sh_dig[idx_q];
    cur_dp  = sh_dp[idx_q];
    if (pend_q) begin
      cur_dig = bus.digits_in[idx_q];
      cur_dp  = bus.dp_in[idx_q];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_WIDTH'(1);
    an_d    = an_q;
    sseg_d  = sseg_q;
    tick_d  = 1'b0;
    load    = pend_q;
    unique case (state_q)
      DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = ON;
          cnt_d   = '0;
          an_d    = ~(4'b0001 << idx_q);
          sseg_d  = {~cur_dp, seg7(cur_dig, bus.blank_en)};
        end
      end
      ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = DEAD;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          an_d    = 4'hF;
          sseg_d  = 8'hFF;
          if (idx_q == 2'd3) begin
            tick_d = 1'b1;
            load   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DEAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      an_q    <= 4'hF;
      sseg_q  <= 8'hFF;
      tick_q  <= 1'b0;
      pend_q  <= 1'b1;
      sh_dp   <= '0;
      for (int i = 0; i < 4; i++) sh_dig[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      sseg_q  <= sseg_d;
      tick_q  <= tick_d;
      pend_q  <= 1'b0;
      if (load) begin
        sh_dp <= bus.dp_in;
        for (int i = 0; i < 4; i++) sh_dig[i] <= bus.digits_in[i];
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Random-stimulus bench for sseg_scan_driver against a frame-position model.
// Second instance checks frame_tick spacing with other parameters.
module tb_sseg_scan_driver;

  localparam int N = 4;
  localparam int D = 2;
  localparam int S = N + D;
  localparam int F = 4 * S;
  localparam int F2 = 4 * (7 + 3);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sseg_scan_driver_if bus();
  sseg_scan_driver_if bus2();

  sseg_scan_driver #(
    .DIGIT_CYCLES(N), .DEAD_CYCLES(D), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  sseg_scan_driver #(
    .DIGIT_CYCLES(7), .DEAD_CYCLES(3), .CNT_WIDTH(3)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  int total = 0;
  int bad = 0;
  int k = 0;
  logic [3:0] sd [4];
  logic [3:0] sdp;
  logic       eb;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic rnd();
    for (int i = 0; i < 4; i++) bus.digits_in[i] = 4'($urandom_range(0, 15));
    bus.dp_in    = 4'($urandom);
    bus.blank_en = 1'($urandom);
  endtask

  // One clock: advance the model at the edge, compare at the falling edge.
  task automatic cycle();
    int p, off, d;
    logic [3:0] ean;
    logic [7:0] esg;
    logic       etk;
    @(posedge clk);
    if (reset) begin
      k++;
      p = k % F;
      if (k == 1 || p == 0) begin
        for (int i = 0; i < 4; i++) sd[i] = bus.digits_in[i];
        sdp = bus.dp_in;
      end
      if (p % S == D) eb = bus.blank_en;
    end
    @(negedge clk);
    ean = 4'hF;
    esg = 8'hFF;
    etk = 1'b0;
    if (reset) begin
      p   = k % F;
      off = p % S;
      d   = p / S;
      if (off >= D) begin
        ean       = ~(4'b0001 << d);
        esg[7]    = ~sdp[d];
        esg[6:0]  = (eb && sd[d] > 4'd9) ? 7'h7F : seg_tab[sd[d]];
      end
      etk = (k > 0 && p == 0);
    end
    chk("an", 32'(bus.an), 32'(ean));
    chk("sseg", 32'(bus.sseg), 32'(esg));
    chk("tick", 32'(bus.frame_tick), 32'(etk));
  endtask

  initial begin
    int found;
    int cnt;
    int nt;
    int tt [3];
    reset = 1'b0;
    for (int i = 0; i < 4; i++) bus2.digits_in[i] = 4'h0;
    bus2.dp_in    = 4'h0;
    bus2.blank_en = 1'b0;
    rnd();

    repeat (5) begin
      cycle();
      rnd();
    end

    for (int i = 0; i < 4; i++) bus.digits_in[i] = 4'(i);
    bus.dp_in    = 4'h0;
    bus.blank_en = 1'b1;
    reset = 1'b1;
    repeat (30) cycle();

    for (int i = 0; i < 4; i++) bus.digits_in[i] = 4'h9;
    repeat (F + 8) cycle();
    for (int i = 0; i < 4; i++) bus.digits_in[i] = 4'h5;
    repeat (F + 4) cycle();

    repeat (240) begin
      cycle();
      if ($urandom_range(0, 3) == 0) rnd();
    end

    found = 0;
    for (int i = 0; i < 3 * F && found == 0; i++) begin
      cycle();
      if ((k % F) / S == 2 && (k % F) % S == D + 2) found = 1;
    end
    chk("find_d2", 32'(found), 32'd1);
    #1 reset = 1'b0;
    k = 0;
    #1;
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_sseg", 32'(bus.sseg), 32'hFF);
    chk("rst_tick", 32'(bus.frame_tick), 32'h0);
    @(negedge clk);
    repeat (3) cycle();
    rnd();
    reset = 1'b1;
    repeat (120) begin
      cycle();
      rnd();
    end

    cycle();
    reset = 1'b0;
    k = 0;
    cycle();
    reset = 1'b1;
    cnt = 0;
    nt = 0;
    tt = '{-1, -1, -1};
    for (int i = 0; i < 4 * F2 && nt < 3; i++) begin
      cycle();
      cnt++;
      if (bus2.frame_tick) begin
        tt[nt] = cnt;
        nt++;
      end
    end
    chk("tick2_first", 32'(tt[0]), 32'(F2));
    chk("tick2_gap1", 32'(tt[1] - tt[0]), 32'(F2));
    chk("tick2_gap2", 32'(tt[2] - tt[1]), 32'(F2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
